// File: rtl/bc_pkg.sv
// Shared constants for the accumulator-CPU I/O and interrupt sequencer.
// Holds the io_op bit positions, the interrupt state encoding and the RT one-hot codes.
package bc_pkg;

    localparam int IO_INP = 5;
    localparam int IO_OUT = 4;
    localparam int IO_SKI = 3;
    localparam int IO_SKO = 2;
    localparam int IO_ION = 1;
    localparam int IO_IOF = 0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PEND = 3'd1,
        ST_RT0  = 3'd2,
        ST_RT1  = 3'd3,
        ST_RT2  = 3'd4
    } intr_state_t;

    localparam logic [2:0] RT_NONE = 3'b000;
    localparam logic [2:0] RT_0    = 3'b001;
    localparam logic [2:0] RT_1    = 3'b010;
    localparam logic [2:0] RT_2    = 3'b100;

endpackage

// File: rtl/io_port_hs.sv
// One I/O direction: data register, ready flag and valid/ready handshake to the device.
// Latency: register and flag update on the clk edge after the event; hs_o is registered.
// Backpressure: input side refuses bytes while its flag is set; output side holds valid until the printer accepts.
module io_port_hs #(
    parameter int DATA_W = 8,
    parameter bit IS_IN  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_evt,
    input  logic [DATA_W-1:0] cpu_dat,
    input  logic              peer_vld,
    input  logic [DATA_W-1:0] peer_dat,
    input  logic              peer_rdy,
    output logic              hs_o,
    output logic [DATA_W-1:0] dat,
    output logic              flag
);

    localparam logic FLAG_RST = IS_IN ? 1'b0 : 1'b1;

    logic [DATA_W-1:0] dat_q, dat_d;
    logic              flag_q, flag_d;
    logic              pend_q, pend_d;
    logic              fire;

    always_comb begin
        dat_d  = dat_q;
        flag_d = flag_q;
        pend_d = pend_q;
        fire   = 1'b0;
        if (IS_IN) begin
            // A keyboard byte landing in the same cycle as INP keeps the flag set.
            fire = peer_vld & ~flag_q;
            if (cpu_evt) flag_d = 1'b0;
            if (fire) begin
                flag_d = 1'b1;
                dat_d  = peer_dat;
            end
        end else begin
            // OUT overrides a completing printer handshake.
            fire = pend_q & peer_rdy;
            if (fire) begin
                pend_d = 1'b0;
                flag_d = 1'b1;
            end
            if (cpu_evt) begin
                pend_d = 1'b1;
                flag_d = 1'b0;
                dat_d  = cpu_dat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dat_q  <= '0;
            flag_q <= FLAG_RST;
            pend_q <= 1'b0;
        end else begin
            dat_q  <= dat_d;
            flag_q <= flag_d;
            pend_q <= pend_d;
        end
    end

    assign hs_o = IS_IN ? ~flag_q : pend_q;
    assign dat  = dat_q;
    assign flag = flag_q;

endmodule

// File: rtl/io_intr_ctrl.sv
// Register-I/O instruction executor and RT0-RT2 interrupt sequencer; vector selectable with INTR_VEC_EN.
// Latency: skip/ac_ld_inpr combinational in the io_exec cycle; flags, registers and rt update on the next clk edge.
// Backpressure: keyboard ready = ~FGI; printer byte stays valid until out_ready; OUT overwrites a pending byte.
module io_intr_ctrl
    import bc_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 12,
    parameter logic [ADDR_W-1:0] VEC_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_end,
    input  logic              fetch_t0,
    input  logic              io_exec,
    input  logic [5:0]        io_op,
    input  logic [DATA_W-1:0] ac_low,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [DATA_W-1:0] inpr,
    output logic              ac_ld_inpr,
    output logic              skip,
    output logic              ien,
    output logic              fgi,
    output logic              fgo,
    output logic              r_flag,
    output logic              intr_cycle,
    output logic [2:0]        rt,
    output logic [ADDR_W-1:0] vec_addr
);

    logic do_inp, do_out, do_ski, do_sko, do_ion, do_iof;

    intr_state_t state_q, state_d;
    logic        r_q, r_d;
    logic        ien_q, ien_d;

    // Only the highest set io_op bit executes.
    always_comb begin
        do_inp = 1'b0;
        do_out = 1'b0;
        do_ski = 1'b0;
        do_sko = 1'b0;
        do_ion = 1'b0;
        do_iof = 1'b0;
        if (io_exec) begin
            if (io_op[IO_INP])      do_inp = 1'b1;
            else if (io_op[IO_OUT]) do_out = 1'b1;
            else if (io_op[IO_SKI]) do_ski = 1'b1;
            else if (io_op[IO_SKO]) do_sko = 1'b1;
            else if (io_op[IO_ION]) do_ion = 1'b1;
            else if (io_op[IO_IOF]) do_iof = 1'b1;
        end
    end

    io_port_hs #(.DATA_W(DATA_W), .IS_IN(1'b1)) u_kbd (
        .clk      (clk),
        .rst      (rst),
        .cpu_evt  (do_inp),
        .cpu_dat  ('0),
        .peer_vld (in_valid),
        .peer_dat (in_data),
        .peer_rdy (1'b1),
        .hs_o     (in_ready),
        .dat      (inpr),
        .flag     (fgi)
    );

    io_port_hs #(.DATA_W(DATA_W), .IS_IN(1'b0)) u_prn (
        .clk      (clk),
        .rst      (rst),
        .cpu_evt  (do_out),
        .cpu_dat  (ac_low),
        .peer_vld (1'b0),
        .peer_dat ('0),
        .peer_rdy (out_ready),
        .hs_o     (out_valid),
        .dat      (out_data),
        .flag     (fgo)
    );

    assign ac_ld_inpr = do_inp;
    assign skip       = (do_ski & fgi) | (do_sko & fgo);

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        ien_d   = ien_q;
        if (do_ion) ien_d = 1'b1;
        if (do_iof) ien_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (instr_end && ien_q && (fgi || fgo)) begin
                    state_d = ST_PEND;
                    r_d     = 1'b1;
                end
            end
            ST_PEND: if (fetch_t0) state_d = ST_RT0;
            ST_RT0:  state_d = ST_RT1;
            ST_RT1:  state_d = ST_RT2;
            ST_RT2: begin
                // Clearing IEN here outranks any stray ION.
                state_d = ST_IDLE;
                r_d     = 1'b0;
                ien_d   = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                r_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            r_q     <= 1'b0;
            ien_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            ien_q   <= ien_d;
        end
    end

    always_comb begin
        rt = RT_NONE;
        case (state_q)
            ST_RT0:  rt = RT_0;
            ST_RT1:  rt = RT_1;
            ST_RT2:  rt = RT_2;
            default: rt = RT_NONE;
        endcase
    end

    assign ien        = ien_q;
    assign r_flag     = r_q;
    assign intr_cycle = r_q;

`ifdef INTR_VEC_EN
    assign vec_addr = VEC_ADDR;
`else
    // Classic return slot at address 0; VEC_ADDR has no effect in this build.
    localparam logic [ADDR_W-1:0] VEC_NONE = VEC_ADDR & {ADDR_W{1'b0}};
    assign vec_addr = VEC_NONE;
`endif

endmodule

// File: tb/tb_io_intr_ctrl.sv
// Self-checking bench for io_intr_ctrl: directed scenarios, then random stimulus against a behavioural model.
module tb_io_intr_ctrl;

    localparam logic [11:0] TB_VEC = 12'h100;
`ifdef INTR_VEC_EN
    localparam logic [11:0] EXP_VEC = TB_VEC;
`else
    localparam logic [11:0] EXP_VEC = 12'h000;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_end = 1'b0, fetch_t0 = 1'b0, io_exec = 1'b0;
    logic [5:0]  io_op = '0;
    logic [7:0]  ac_low = '0, in_data = '0;
    logic        in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid, ac_ld_inpr, skip, ien, fgi, fgo, r_flag, intr_cycle;
    logic [7:0]  out_data, inpr;
    logic [2:0]  rt;
    logic [11:0] vec_addr;

    int errors = 0;
    int checks = 0;

    // Behavioural model; stage 0=idle, 1=pending, 2..4 = RT0..RT2.
    logic [7:0] m_inpr = '0, m_outr = '0;
    logic       m_fgi = 1'b0, m_fgo = 1'b1, m_ien = 1'b0, m_ovld = 1'b0;
    int         m_stage = 0;

    io_intr_ctrl #(.DATA_W(8), .ADDR_W(12), .VEC_ADDR(TB_VEC)) dut (
        .clk(clk), .rst(rst), .instr_end(instr_end), .fetch_t0(fetch_t0),
        .io_exec(io_exec), .io_op(io_op), .ac_low(ac_low),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .inpr(inpr), .ac_ld_inpr(ac_ld_inpr), .skip(skip), .ien(ien),
        .fgi(fgi), .fgo(fgo), .r_flag(r_flag), .intr_cycle(intr_cycle),
        .rt(rt), .vec_addr(vec_addr)
    );

    always #5 clk = ~clk;

    function automatic int cur_op();
        int r = -1;
        if (io_exec) begin
            for (int b = 0; b < 6; b++) if (io_op[b]) r = b;
        end
        return r;
    endfunction

    function automatic logic exp_skip();
        int op = cur_op();
        if (op == 3) return m_fgi;
        if (op == 2) return m_fgo;
        return 1'b0;
    endfunction

    function automatic logic [2:0] exp_rt();
        if (m_stage == 2) return 3'b001;
        if (m_stage == 3) return 3'b010;
        if (m_stage == 4) return 3'b100;
        return 3'b000;
    endfunction

    task automatic model_step();
        int         op = cur_op();
        logic       kb = in_valid && !m_fgi;
        logic       prn = m_ovld && out_ready;
        logic       trig = (m_stage == 0) && instr_end && m_ien && (m_fgi || m_fgo);
        logic [7:0] n_inpr = m_inpr, n_outr = m_outr;
        logic       n_fgi = m_fgi, n_fgo = m_fgo, n_ien = m_ien, n_ovld = m_ovld;
        int         n_stage = m_stage;
        if (op == 5) n_fgi = 1'b0;
        if (kb) begin n_fgi = 1'b1; n_inpr = in_data; end
        if (prn) begin n_ovld = 1'b0; n_fgo = 1'b1; end
        if (op == 4) begin n_outr = ac_low; n_fgo = 1'b0; n_ovld = 1'b1; end
        if (op == 1) n_ien = 1'b1;
        if (op == 0) n_ien = 1'b0;
        if (m_stage == 4) n_ien = 1'b0;
        if (m_stage == 0) n_stage = trig ? 1 : 0;
        else if (m_stage == 1) n_stage = fetch_t0 ? 2 : 1;
        else n_stage = (m_stage == 4) ? 0 : m_stage + 1;
        if (rst) begin
            n_inpr = '0; n_outr = '0; n_fgi = 1'b0; n_fgo = 1'b1;
            n_ien = 1'b0; n_ovld = 1'b0; n_stage = 0;
        end
        m_inpr = n_inpr; m_outr = n_outr; m_fgi = n_fgi; m_fgo = n_fgo;
        m_ien = n_ien; m_ovld = n_ovld; m_stage = n_stage;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++; if (fgo !== 1'b1)      begin errors++; $display("FAIL reset_fgo got=%b exp=1", fgo); end
        checks++; if (fgi !== 1'b0)      begin errors++; $display("FAIL reset_fgi got=%b exp=0", fgi); end
        checks++; if (ien !== 1'b0)      begin errors++; $display("FAIL reset_ien got=%b exp=0", ien); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (rt !== 3'b000)     begin errors++; $display("FAIL reset_rt got=%b exp=000", rt); end
        checks++; if (r_flag !== 1'b0)   begin errors++; $display("FAIL reset_r got=%b exp=0", r_flag); end
        checks++; if (inpr !== 8'h00)    begin errors++; $display("FAIL reset_inpr got=%h exp=00", inpr); end
    endtask

    task automatic test_keyboard_inp();
        in_valid = 1'b1; in_data = 8'h41;
        tick();
        in_valid = 1'b0;
        #1;
        checks++; if (fgi !== 1'b1)      begin errors++; $display("FAIL kbd_fgi got=%b exp=1", fgi); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL kbd_in_ready got=%b exp=0", in_ready); end
        io_exec = 1'b1; io_op = 6'b100000;
        #1;
        checks++; if (ac_ld_inpr !== 1'b1) begin errors++; $display("FAIL inp_ac_ld got=%b exp=1", ac_ld_inpr); end
        checks++; if (inpr !== 8'h41)    begin errors++; $display("FAIL inp_inpr got=%h exp=41", inpr); end
        tick();
        io_exec = 1'b0;
        #1;
        checks++; if (fgi !== 1'b0)      begin errors++; $display("FAIL inp_fgi_clr got=%b exp=0", fgi); end
        checks++; if (ac_ld_inpr !== 1'b0) begin errors++; $display("FAIL inp_ac_ld_idle got=%b exp=0", ac_ld_inpr); end
    endtask

    task automatic test_out_sko();
        io_exec = 1'b1; io_op = 6'b010000; ac_low = 8'h5A;
        tick();
        io_op = 6'b000100;
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL out_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== 8'h5A) begin errors++; $display("FAIL out_data got=%h exp=5a", out_data); end
        checks++; if (fgo !== 1'b0)       begin errors++; $display("FAIL out_fgo got=%b exp=0", fgo); end
        checks++; if (skip !== 1'b0)      begin errors++; $display("FAIL sko_busy got=%b exp=0", skip); end
        tick();
        io_exec = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        checks++; if (fgo !== 1'b1)       begin errors++; $display("FAIL prn_fgo got=%b exp=1", fgo); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL prn_valid got=%b exp=0", out_valid); end
        io_exec = 1'b1; io_op = 6'b000100;
        #1;
        checks++; if (skip !== 1'b1)      begin errors++; $display("FAIL sko_ready got=%b exp=1", skip); end
        tick();
        io_exec = 1'b0;
    endtask

    task automatic test_interrupt();
        io_exec = 1'b1; io_op = 6'b000010;
        tick();
        io_exec = 1'b0;
        in_valid = 1'b1; in_data = 8'($urandom);
        tick();
        in_valid = 1'b0;
        #1;
        checks++; if (ien !== 1'b1)      begin errors++; $display("FAIL ion_ien got=%b exp=1", ien); end
        instr_end = 1'b1;
        tick();
        instr_end = 1'b0;
        #1;
        checks++; if (r_flag !== 1'b1 || intr_cycle !== 1'b1) begin errors++; $display("FAIL intr_r got=%b/%b exp=1/1", r_flag, intr_cycle); end
        checks++; if (rt !== 3'b000)     begin errors++; $display("FAIL pend_rt got=%b exp=000", rt); end
        fetch_t0 = 1'b1;
        tick();
        fetch_t0 = 1'b0;
        #1;
        checks++; if (rt !== 3'b001)     begin errors++; $display("FAIL rt0 got=%b exp=001", rt); end
        checks++; if (vec_addr !== EXP_VEC) begin errors++; $display("FAIL rt0_vec got=%h exp=%h", vec_addr, EXP_VEC); end
        tick();
        checks++; if (rt !== 3'b010)     begin errors++; $display("FAIL rt1 got=%b exp=010", rt); end
        tick();
        checks++; if (rt !== 3'b100)     begin errors++; $display("FAIL rt2 got=%b exp=100", rt); end
        checks++; if (ien !== 1'b1)      begin errors++; $display("FAIL rt2_ien got=%b exp=1", ien); end
        tick();
        checks++; if (rt !== 3'b000)     begin errors++; $display("FAIL rt_done got=%b exp=000", rt); end
        checks++; if (ien !== 1'b0 || r_flag !== 1'b0) begin errors++; $display("FAIL rt_done_flags ien/r got=%b/%b exp=0/0", ien, r_flag); end
    endtask

    task automatic test_priority();
        io_exec = 1'b1; io_op = 6'b100000;
        tick();
        io_op = 6'b100010; in_valid = 1'b1; in_data = 8'hC3;
        #1;
        checks++; if (ac_ld_inpr !== 1'b1) begin errors++; $display("FAIL prio_ac_ld got=%b exp=1", ac_ld_inpr); end
        tick();
        io_exec = 1'b0; in_valid = 1'b0;
        #1;
        checks++; if (fgi !== 1'b1)      begin errors++; $display("FAIL prio_fgi got=%b exp=1", fgi); end
        checks++; if (inpr !== 8'hC3)    begin errors++; $display("FAIL prio_inpr got=%h exp=c3", inpr); end
        checks++; if (ien !== 1'b0)      begin errors++; $display("FAIL prio_ien got=%b exp=0", ien); end
    endtask

    task automatic test_reset_mid();
        io_exec = 1'b1; io_op = 6'b000010;
        tick();
        io_exec = 1'b0; instr_end = 1'b1;
        tick();
        instr_end = 1'b0; fetch_t0 = 1'b1;
        tick();
        fetch_t0 = 1'b0;
        tick();
        checks++; if (rt !== 3'b010)     begin errors++; $display("FAIL mid_rt1 got=%b exp=010", rt); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++; if (rt !== 3'b000)     begin errors++; $display("FAIL mid_rst_rt got=%b exp=000", rt); end
        checks++; if (r_flag !== 1'b0)   begin errors++; $display("FAIL mid_rst_r got=%b exp=0", r_flag); end
        checks++; if (fgo !== 1'b1 || fgi !== 1'b0 || ien !== 1'b0) begin errors++; $display("FAIL mid_rst_flags fgo/fgi/ien got=%b/%b/%b exp=1/0/0", fgo, fgi, ien); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 1500; n++) begin
            rst       = ($urandom_range(63) == 0);
            instr_end = ($urandom_range(3) == 0);
            fetch_t0  = ($urandom_range(2) == 0);
            io_exec   = ($urandom_range(2) == 0);
            io_op     = ($urandom_range(3) == 0) ? 6'($urandom) : 6'(1 << $urandom_range(5));
            ac_low    = 8'($urandom);
            in_valid  = $urandom_range(1) == 1;
            in_data   = 8'($urandom);
            out_ready = $urandom_range(1) == 1;
            #1;
            checks++; if (inpr !== m_inpr)     begin errors++; $display("FAIL rnd_inpr n=%0d got=%h exp=%h", n, inpr, m_inpr); end
            checks++; if (out_data !== m_outr) begin errors++; $display("FAIL rnd_out_data n=%0d got=%h exp=%h", n, out_data, m_outr); end
            checks++; if (fgi !== m_fgi || in_ready !== !m_fgi) begin errors++; $display("FAIL rnd_fgi n=%0d got=%b/%b exp=%b", n, fgi, in_ready, m_fgi); end
            checks++; if (fgo !== m_fgo)       begin errors++; $display("FAIL rnd_fgo n=%0d got=%b exp=%b", n, fgo, m_fgo); end
            checks++; if (out_valid !== m_ovld) begin errors++; $display("FAIL rnd_out_valid n=%0d got=%b exp=%b", n, out_valid, m_ovld); end
            checks++; if (ien !== m_ien)       begin errors++; $display("FAIL rnd_ien n=%0d got=%b exp=%b", n, ien, m_ien); end
            checks++; if (r_flag !== (m_stage != 0) || intr_cycle !== (m_stage != 0)) begin errors++; $display("FAIL rnd_r n=%0d got=%b exp=%b", n, r_flag, m_stage != 0); end
            checks++; if (rt !== exp_rt())     begin errors++; $display("FAIL rnd_rt n=%0d got=%b exp=%b", n, rt, exp_rt()); end
            checks++; if (skip !== exp_skip()) begin errors++; $display("FAIL rnd_skip n=%0d got=%b exp=%b", n, skip, exp_skip()); end
            checks++; if (ac_ld_inpr !== (cur_op() == 5)) begin errors++; $display("FAIL rnd_ac_ld n=%0d got=%b exp=%b", n, ac_ld_inpr, cur_op() == 5); end
            checks++; if (vec_addr !== EXP_VEC) begin errors++; $display("FAIL rnd_vec n=%0d got=%h exp=%h", n, vec_addr, EXP_VEC); end
            tick();
        end
        rst = 1'b0; instr_end = 1'b0; fetch_t0 = 1'b0; io_exec = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        #1;
        test_reset();
        test_keyboard_inp();
        test_out_sko();
        test_interrupt();
        test_priority();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
